// File: rtl/mips_muldiv_pkg.sv
// Shared types and helpers for the HI/LO multiply/divide unit.
package mips_muldiv_pkg;

  localparam int unsigned WIDTH = 32;

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpDiv   = 3'd2,
    OpDivu  = 3'd3,
    OpMthi  = 3'd4,
    OpMtlo  = 3'd5,
    OpRsv6  = 3'd6,
    OpRsv7  = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StFix
  } muldiv_state_t;

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
// Multiply: acc = {partial product high, remaining multiplier bits}.
// Divide:   acc = {partial remainder, remaining dividend / accumulated quotient}.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               div_mode,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Next accumulator for the selected mode
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // Partial remainder shifted left with the next dividend bit brought in
    shifted = acc[2*WIDTH-1:WIDTH-1];
    diff    = shifted - {1'b0, operand};
    if (div_mode) begin
      // A set top bit means the trial subtraction borrowed: restore
      if (diff[WIDTH]) begin
        acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end else begin
      // Carry out of the add lands in the top bit after the right shift
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
module hilo_muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32  // one result bit per iteration, so must equal WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import mips_muldiv_pkg::*;

  localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;

  muldiv_state_t      state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step_acc, prod;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   rs_mag, rt_mag, quo, rem;
  logic               sign_q, sign_d, rsign_q, rsign_d, div_q, div_d;
  logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic               signed_op;
  muldiv_op_t         op_dec;

  assign op_dec    = muldiv_op_t'(op);
  assign signed_op = (op_dec == OpMult) || (op_dec == OpDiv);
  assign rs_mag    = signed_op ? abs_val(rs_data) : rs_data;
  assign rt_mag    = signed_op ? abs_val(rt_data) : rt_data;

  assign quo  = acc_q[WIDTH-1:0];
  assign rem  = acc_q[2*WIDTH-1:WIDTH];
  assign prod = sign_q ? -acc_q : acc_q;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc      (acc_q),
    .operand  (opnd_q),
    .div_mode (div_q),
    .acc_next (step_acc)
  );

  // Next-state logic: issue decode, iteration, and sign fix-up
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    sign_d  = sign_q;
    rsign_d = rsign_q;
    div_d   = div_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          case (op_dec)
            OpMult, OpMultu: begin
              acc_d   = {{WIDTH{1'b0}}, rt_mag};
              opnd_d  = rs_mag;
              sign_d  = signed_op & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
              rsign_d = 1'b0;
              div_d   = 1'b0;
              cnt_d   = CntW'(ITER - 1);
              busy_d  = 1'b1;
              state_d = StMul;
            end
            OpDiv, OpDivu: begin
              if (rt_data == '0) begin
                // Retire immediately; HI/LO keep their old contents
                done_d = 1'b1;
                dbz_d  = 1'b1;
              end else begin
                acc_d   = {{WIDTH{1'b0}}, rs_mag};
                opnd_d  = rt_mag;
                sign_d  = signed_op & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                rsign_d = signed_op & rs_data[WIDTH-1];
                div_d   = 1'b1;
                cnt_d   = CntW'(ITER - 1);
                busy_d  = 1'b1;
                state_d = StDiv;
              end
            end
            OpMthi: begin
              hi_d   = rs_data;
              done_d = 1'b1;
            end
            OpMtlo: begin
              lo_d   = rs_data;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      StMul, StDiv: begin
        acc_d = step_acc;
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFix: begin
        if (div_q) begin
          lo_d = sign_q ? -quo : quo;
          hi_d = rsign_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = prod;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      sign_q  <= 1'b0;
      rsign_q <= 1'b0;
      div_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      sign_q  <= sign_d;
      rsign_q <= rsign_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed and random checks of hilo_muldiv_unit against an arithmetic model.
module tb_hilo_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   op;
  logic [W-1:0] rs_data, rt_data;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;

  // Model of the architectural HI/LO contents
  logic [W-1:0] mhi = '0;
  logic [W-1:0] mlo = '0;

  hilo_muldiv_unit #(
    .WIDTH(W),
    .ITER (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected effect of one issue. done_at is the number of falling edges after
  // the accepting rising edge at which done is first seen (0 = never).
  task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int done_at, output logic dz);
    longint      sa, sb, sp, q, r;
    logic [63:0] up;
    sa = $signed(a);
    sb = $signed(b);
    done_at = 34;
    dz      = 1'b0;
    case (o)
      3'd0: begin
        sp  = sa * sb;
        mhi = sp[63:32];
        mlo = sp[31:0];
      end
      3'd1: begin
        up  = {32'b0, a} * {32'b0, b};
        mhi = up[63:32];
        mlo = up[31:0];
      end
      3'd2, 3'd3: begin
        if (b == 0) begin
          done_at = 1;
          dz      = 1'b1;
        end else if (o == 3'd2) begin
          q   = sa / sb;
          r   = sa % sb;
          mlo = q[31:0];
          mhi = r[31:0];
        end else begin
          mlo = a / b;
          mhi = a % b;
        end
      end
      3'd4: begin
        mhi     = a;
        done_at = 1;
      end
      3'd5: begin
        mlo     = a;
        done_at = 1;
      end
      default: done_at = 0;
    endcase
  endtask

  // Present one request for a single rising edge; returns on the falling edge after it
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int n, output int busy_cnt);
    n        = n0;
    busy_cnt = 0;
    while (done !== 1'b1 && n < 200) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) check("done_timeout", {63'b0, done}, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    int   exp_at, n, bc;
    logic dz;
    model(o, a, b, exp_at, dz);
    issue(o, a, b);
    wait_done(1, n, bc);
    check({tag, "_latency"}, n, exp_at);
    check({tag, "_busy_cycles"}, bc, exp_at - 1);
    check({tag, "_dbz"}, {63'b0, div_by_zero}, {63'b0, dz});
    check({tag, "_busy_at_done"}, {63'b0, busy}, 64'd0);
    check({tag, "_hi"}, hi, mhi);
    check({tag, "_lo"}, lo, mlo);
    @(negedge clk);
    check({tag, "_done_pulse"}, {63'b0, done}, 64'd0);
  endtask

  initial begin
    int           exp_at, n, bc, seen, last, dcount;
    logic         dz;
    logic [2:0]   o;
    logic [W-1:0] a, b;

    reset   = 1'b1;
    start   = 1'b0;
    op      = '0;
    rs_data = '0;
    rt_data = '0;
    repeat (3) @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", {63'b0, busy}, 0);
    check("rst_done", {63'b0, done}, 0);
    check("rst_dbz", {63'b0, div_by_zero}, 0);
    reset = 1'b0;

    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_hi_c", hi, 32'hFFFF_FFFE);
    check("multu_max_lo_c", lo, 32'h0000_0001);

    run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7);
    check("mult_neg_hi_c", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo_c", lo, 32'hFFFF_FFEB);

    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_lo_c", lo, 32'hFFFF_FFFD);
    check("div_neg_hi_c", hi, 32'hFFFF_FFFF);

    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo_c", lo, 32'h8000_0000);
    check("div_ovf_hi_c", hi, 32'h0);

    run_op("divu_zero", 3'd3, 32'd100, 32'd0);
    check("divu_zero_hi_c", hi, 32'h0);
    check("divu_zero_lo_c", lo, 32'h8000_0000);

    run_op("mthi", 3'd4, 32'h1234_5678, 32'd0);
    check("mthi_c", hi, 32'h1234_5678);

    // MTLO arriving mid-divide must be dropped
    model(3'd3, 32'd5000, 32'd13, exp_at, dz);
    issue(3'd3, 32'd5000, 32'd13);
    repeat (4) @(negedge clk);
    start   = 1'b1;
    op      = 3'd5;
    rs_data = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, n, bc);
    check("mtlo_busy_latency", n, exp_at);
    check("mtlo_busy_lo", lo, mlo);
    check("mtlo_busy_hi", hi, mhi);
    check("mtlo_busy_lo_c", lo, 32'd384);

    // Reset in the middle of a divide
    issue(3'd3, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mhi   = '0;
    mlo   = '0;
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_busy", {63'b0, busy}, 0);
    check("abort_done", {63'b0, done}, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    check("abort_quiet", seen, 0);

    run_op("divu_1000_7", 3'd3, 32'd1000, 32'd7);
    check("divu_1000_7_lo_c", lo, 32'd142);
    check("divu_1000_7_hi_c", hi, 32'd6);

    // Reserved opcode does nothing
    issue(3'd6, 32'hCAFE_F00D, 32'h1111_2222);
    seen = 0;
    repeat (5) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      @(negedge clk);
    end
    check("rsv_quiet", seen, 0);
    check("rsv_hi", hi, mhi);
    check("rsv_lo", lo, mlo);

    // start held high: a new multiply is taken in every done cycle
    @(negedge clk);
    start   = 1'b1;
    op      = 3'd1;
    rs_data = 32'd3;
    rt_data = 32'd5;
    n       = 0;
    last    = 0;
    dcount  = 0;
    while (dcount < 3 && n < 300) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) begin
        dcount++;
        check("b2b_lo", lo, 32'd15);
        check("b2b_hi", hi, 32'd0);
        check("b2b_gap", n - last, 34);
        last = n;
        if (dcount == 3) start = 1'b0;
      end
    end
    check("b2b_count", dcount, 3);
    mhi = 32'd0;
    mlo = 32'd15;
    @(negedge clk);
    check("b2b_stop_busy", {63'b0, busy}, 0);

    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 5));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) b = '0;
      else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      run_op("rand", o, a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide unit with the architectural HI/LO registers for the MIPS datapath.
- Sits downstream of the register-file read and ALU operand path; consumes Rs/Rt data for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Exposes HI/LO to the writeback mux for MFHI/MFLO.
- Drives a busy stall to the control unit while an iterative operation runs.

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- ITER, 32, iteration cycles per multiply/divide. Must equal WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  issue request, sampled on the rising edge.
- op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved.
- rs_data  input  WIDTH  Rs operand (dividend / multiplicand / MTxx source).
- rt_data  input  WIDTH  Rt operand (divisor / multiplier).
- busy  output  1  iterative operation in progress; control stalls on MULT/DIV/MFHI/MFLO while high.
- done  output  1  one-cycle pulse when an operation retires.
- div_by_zero  output  1  one-cycle pulse, coincident with done, for DIV/DIVU with rt_data == 0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset state: hi = 0, lo = 0, busy = 0, done = 0, div_by_zero = 0, FSM in IDLE, iteration counter = 0.
- Reset mid-operation aborts the operation. HI/LO return to 0 and no done pulse is produced.
- FSM states: IDLE, MUL, DIV, FIX.
- start is accepted only in IDLE. start while busy is ignored; no queueing.
- Reserved op codes: ignored, no state change, no done.
- MTHI / MTLO, accepted at edge E0:
  - hi (or lo) <= rs_data at E0; FSM stays in IDLE.
  - done = 1 for the cycle after E0; busy stays 0.
- MULT / MULTU, accepted at E0:
  - Latch operand magnitudes. MULTU uses the raw values. MULT uses two's-complement absolute values and records sign = rs[31] ^ rt[31].
  - busy = 1 after E0. State MUL, counter = ITER-1.
  - Edges E1..E32 each perform one shift-add step on a 2*WIDTH accumulator; counter decrements and wraps to FIX after 0.
  - At E33 (FIX): if sign, negate the 64-bit product. {hi, lo} <= product. busy <= 0, done <= 1.
  - done drops at E34. Result visible 33 edges after acceptance.
- DIV / DIVU, accepted at E0:
  - If rt_data == 0: no iteration. hi/lo unchanged. At E0 done <= 1 and div_by_zero <= 1 (pulse in the cycle after E0). busy stays 0.
  - Otherwise: restoring division on magnitudes. DIV records qsign = rs[31] ^ rt[31] and rsign = rs[31].
  - Edges E1..E32: one quotient bit per edge.
  - At E33 (FIX): lo <= qsign ? -q : q; hi <= rsign ? -r : r. Quotient truncates toward zero; remainder takes the dividend's sign. busy <= 0, done <= 1.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0 (no trap).
- Operand widths: magnitude of 0x80000000 is 0x80000000, held as unsigned WIDTH-bit. Accumulators are 2*WIDTH (product) and WIDTH+1 (partial remainder).
- Outputs are registered; hi/lo change only at reset, MTxx acceptance, or FIX.
- start in the done cycle is accepted normally; back-to-back throughput is 34 cycles per multiply/divide.

Decomposition:
- Shared package mips_muldiv_pkg:
  - muldiv_op_t enum (6 codes plus reserved);
  - muldiv_state_t enum {IDLE, MUL, DIV, FIX};
  - localparam WIDTH = 32;
  - function abs_val (two's-complement magnitude).
- One sub-module: muldiv_step, combinational. Given accumulator, operand and a mode bit, returns the next accumulator for one shift-add or one restoring-subtract iteration.
- The top level holds the FSM, counter, sign flags and HI/LO.

Test Plan:
- MULTU rs = 0xFFFFFFFF, rt = 0xFFFFFFFF -> done exactly 33 edges after acceptance; hi = 0xFFFFFFFE, lo = 0x00000001; busy high for 33 cycles.
- MULT rs = 0xFFFFFFFD (-3), rt = 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. Then DIV rs = 0xFFFFFFF9 (-7), rt = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIV rs = 0x80000000, rt = 0xFFFFFFFF -> lo = 0x80000000, hi = 0. Then DIVU rs = 100, rt = 0 -> done and div_by_zero pulse one cycle after acceptance; hi/lo unchanged; busy never asserts.
- MTHI rs = 0x12345678 at IDLE -> hi = 0x12345678 next cycle, done pulse, busy 0. MTLO issued at cycle 5 of a running DIVU -> ignored; lo ends with the DIVU quotient.
- Reset asserted on iteration 10 of DIVU 1000/7 -> next cycle hi = lo = 0, busy = 0, no done. A subsequent DIVU 1000/7 -> lo = 142, hi = 6.
- Reserved op 6 with start -> no done, busy 0, hi/lo unchanged. start held high continuously with MULTU 3×5 -> a new operation starts in each done cycle; every result is lo = 15, hi = 0.
